scr1_tapc_dr_chain: RTL and testbench
=====================================

SCR1_TAPC_DR_CHAIN -- requirements
Module: scr1_tapc_dr_chain

Interface
REQ-001 Parameter SCR1_WIDTH, default 8, meaning data register length in bits, legal range 1..64.
REQ-002 Parameter SCR1_RESET_VALUE, default '0, meaning reset value of the shift and update registers.
REQ-003 Parameter SCR1_MSB_FIRST, default 0, meaning shift direction: 0 = LSB first, 1 = MSB first.
REQ-004 Localparam CW = $clog2(SCR1_WIDTH+2), meaning shift counter width.
REQ-005 clk  in  1  TCK-domain clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rst_n_sync  in  1  synchronous reset, active-low.
REQ-008 fsm_dr_select  in  1  enables all DR operations.
REQ-009 fsm_dr_capture  in  1  Capture-DR strobe.
REQ-010 fsm_dr_shift  in  1  Shift-DR strobe.
REQ-011 fsm_dr_update  in  1  Update-DR strobe.
REQ-012 din_serial  in  1  TDI bit.
REQ-013 din_parallel  in  SCR1_WIDTH  capture data.
REQ-014 dout_serial  out  1  TDO bit.
REQ-015 dout_parallel  out  SCR1_WIDTH  live shift register contents.
REQ-016 upd_data  out  SCR1_WIDTH  update (shadow) register.
REQ-017 upd_valid  out  1  update data pending for the consumer.
REQ-018 upd_ack  in  1  consumer accepts upd_data.
REQ-019 shift_cnt  out  CW  number of bits shifted since the last capture.
REQ-020 len_err  out  1  the last update followed a shift count other than SCR1_WIDTH.
REQ-021 overrun  out  1  sticky flag: an update occurred while upd_valid was high and not acknowledged.

Function
REQ-022 All operations except reset and handshake shall be qualified by fsm_dr_select; the priority order shall be ~rst_n_sync > capture > shift > update.
REQ-023 Capture: shift_reg <= din_parallel and shift_cnt <= 0 at the next clk edge.
REQ-024 Shift with SCR1_MSB_FIRST=0: shift_reg <= {din_serial, shift_reg[W-1:1]}, and dout_serial = shift_reg[0].
REQ-025 Shift with SCR1_MSB_FIRST=1: shift_reg <= {shift_reg[W-2:0], din_serial}, and dout_serial = shift_reg[W-1].
REQ-026 With SCR1_WIDTH=1, shift shall load shift_reg <= din_serial in both modes.
REQ-027 Each shift shall increment shift_cnt, saturating at SCR1_WIDTH+1 with no wrap-around.
REQ-028 Update: upd_data <= shift_reg, upd_valid <= 1, and len_err <= (shift_cnt != SCR1_WIDTH), all at the same edge.
REQ-029 If update occurs while upd_valid=1 and upd_ack=0, overrun <= 1 and upd_data is still overwritten.
REQ-030 If update occurs with upd_ack=1 in the same cycle, upd_valid shall stay 1 with the new data and overrun shall be unchanged.
REQ-031 upd_ack with upd_valid=1 and no update shall clear upd_valid at the next edge; upd_ack with upd_valid=0 shall be ignored.
REQ-032 upd_ack shall be honoured regardless of fsm_dr_select.
REQ-033 If capture and update are asserted together, capture shall take effect and update shall be ignored.
REQ-034 dout_serial and dout_parallel shall be combinational from shift_reg, with zero latency.

Reset
REQ-035 On rst_n=0 (asynchronous) or rst_n_sync=0 (synchronous): shift_reg = upd_data = SCR1_RESET_VALUE, shift_cnt = 0, upd_valid = 0, len_err = 0, overrun = 0.
REQ-036 A reset asserted mid-shift or with an update pending shall discard all pending state; no upd_valid pulse shall survive it.
REQ-037 overrun shall clear only by reset.

Structure
REQ-038 Shift-direction enum values (LSB/MSB first) shall live in the shared package scr1_tapc_pkg.
REQ-039 The update/handshake stage (upd_data, upd_valid, len_err, overrun) shall be a sub-module named scr1_tapc_dr_upd.
REQ-040 The shift register and counter shall remain in the top module.
REQ-041 Under SCR1_TRGT_SIMULATION, an X-check assertion on all inputs shall be included.

Verification
REQ-042 W=8, LSB-first: capture 0xA5, shift 8 bits of TDI=1 -> dout_serial sequence 1,0,1,0,0,1,0,1 and dout_parallel=0xFF.
REQ-043 W=8, MSB-first: capture 0xA5, shift 8 bits, then update -> TDO sequence 1,0,1,0,0,1,0,1, upd_data=TDI word, upd_valid=1, len_err=0.
REQ-044 W=8: capture, shift 5 bits, update -> len_err=1; shift 12 bits -> shift_cnt saturates at 9.
REQ-045 Two updates without upd_ack -> overrun=1, upd_data = second word; a later upd_ack clears upd_valid while overrun stays 1.
REQ-046 Update with simultaneous upd_ack -> upd_valid stays 1 and overrun stays 0.
REQ-047 rst_n_sync low mid-shift with upd_valid=1 -> all outputs equal reset values on the next edge; with W=1, a shift of TDI=1 gives dout_serial=1.

Source files
------------

// File: rtl/scr1_tapc_pkg.sv
// Shared TAP controller definitions.
// Holds the DR shift-direction encoding and a helper to derive it.
package scr1_tapc_pkg;

    typedef enum logic {
        SCR1_DIR_LSB = 1'b0,
        SCR1_DIR_MSB = 1'b1
    } scr1_shift_dir_e;

    function automatic scr1_shift_dir_e scr1_dir(input bit msb_first);
        return msb_first ? SCR1_DIR_MSB : SCR1_DIR_LSB;
    endfunction

endpackage

// File: rtl/scr1_tapc_dr_upd.sv
// DR update stage: shadow register plus valid/ack handshake.
// Ports: clk, rst_n (async), rst_n_sync (sync), upd_en (qualified
// update strobe), upd_ack, shift_reg/shift_cnt from the shift stage;
// outputs upd_data, upd_valid, len_err, overrun (sticky).
module scr1_tapc_dr_upd
    import scr1_tapc_pkg::*;
#(
    parameter int unsigned            SCR1_WIDTH       = 8,
    parameter logic [SCR1_WIDTH-1:0]  SCR1_RESET_VALUE = '0,
    parameter int unsigned            CW               = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rst_n_sync,
    input  logic                  upd_en,
    input  logic                  upd_ack,
    input  logic [SCR1_WIDTH-1:0] shift_reg,
    input  logic [CW-1:0]         shift_cnt,
    output logic [SCR1_WIDTH-1:0] upd_data,
    output logic                  upd_valid,
    output logic                  len_err,
    output logic                  overrun
);

    localparam logic [CW-1:0] CNT_FULL = CW'(SCR1_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_data  <= SCR1_RESET_VALUE;
            upd_valid <= 1'b0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
        end else if (!rst_n_sync) begin
            upd_data  <= SCR1_RESET_VALUE;
            upd_valid <= 1'b0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
        end else if (upd_en) begin
            upd_data  <= shift_reg;
            upd_valid <= 1'b1;
            len_err   <= (shift_cnt != CNT_FULL);
            // A same-cycle ack consumes the old word, so no overrun then
            if (upd_valid && !upd_ack) begin
                overrun <= 1'b1;
            end
        end else if (upd_valid && upd_ack) begin
            upd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/scr1_tapc_dr_chain.sv
// JTAG data register: capture/shift chain with update handshake stage.
// Ports: clk, rst_n (async), rst_n_sync (sync), fsm_dr_* strobes,
// din_serial/din_parallel in; dout_serial/dout_parallel (live chain),
// upd_data/upd_valid/upd_ack handshake, shift_cnt, len_err, overrun.
module scr1_tapc_dr_chain
    import scr1_tapc_pkg::*;
#(
    parameter int unsigned            SCR1_WIDTH       = 8,
    parameter logic [SCR1_WIDTH-1:0]  SCR1_RESET_VALUE = '0,
    parameter bit                     SCR1_MSB_FIRST   = 1'b0,
    localparam int unsigned           CW = $clog2(SCR1_WIDTH + 2)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rst_n_sync,
    input  logic                  fsm_dr_select,
    input  logic                  fsm_dr_capture,
    input  logic                  fsm_dr_shift,
    input  logic                  fsm_dr_update,
    input  logic                  din_serial,
    input  logic [SCR1_WIDTH-1:0] din_parallel,
    output logic                  dout_serial,
    output logic [SCR1_WIDTH-1:0] dout_parallel,
    output logic [SCR1_WIDTH-1:0] upd_data,
    output logic                  upd_valid,
    input  logic                  upd_ack,
    output logic [CW-1:0]         shift_cnt,
    output logic                  len_err,
    output logic                  overrun
);

    localparam scr1_shift_dir_e DIR     = scr1_dir(SCR1_MSB_FIRST);
    localparam logic [CW-1:0]   CNT_MAX = CW'(SCR1_WIDTH + 1);

    logic [SCR1_WIDTH-1:0] shift_reg;
    logic [SCR1_WIDTH-1:0] shift_nxt;
    logic [CW-1:0]         cnt_nxt;
    logic                  cap_en;
    logic                  sh_en;
    logic                  upd_en;

    // Priority: capture > shift > update
    assign cap_en = fsm_dr_select & fsm_dr_capture;
    assign sh_en  = fsm_dr_select & fsm_dr_shift & ~fsm_dr_capture;
    assign upd_en = fsm_dr_select & fsm_dr_update
                  & ~fsm_dr_capture & ~fsm_dr_shift;

    generate
        if (SCR1_WIDTH == 1) begin : g_w1
            assign shift_nxt   = din_serial;
            assign dout_serial = shift_reg[0];
        end else if (DIR == SCR1_DIR_MSB) begin : g_msb
            assign shift_nxt   = {shift_reg[SCR1_WIDTH-2:0], din_serial};
            assign dout_serial = shift_reg[SCR1_WIDTH-1];
        end else begin : g_lsb
            assign shift_nxt   = {din_serial, shift_reg[SCR1_WIDTH-1:1]};
            assign dout_serial = shift_reg[0];
        end
    endgenerate

    // Saturate one past full length so over-long shifts stay visible
    assign cnt_nxt = (shift_cnt == CNT_MAX) ? shift_cnt
                                            : shift_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= SCR1_RESET_VALUE;
            shift_cnt <= '0;
        end else if (!rst_n_sync) begin
            shift_reg <= SCR1_RESET_VALUE;
            shift_cnt <= '0;
        end else if (cap_en) begin
            shift_reg <= din_parallel;
            shift_cnt <= '0;
        end else if (sh_en) begin
            shift_reg <= shift_nxt;
            shift_cnt <= cnt_nxt;
        end
    end

    assign dout_parallel = shift_reg;

    scr1_tapc_dr_upd #(
        .SCR1_WIDTH       (SCR1_WIDTH),
        .SCR1_RESET_VALUE (SCR1_RESET_VALUE),
        .CW               (CW)
    ) i_upd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_n_sync (rst_n_sync),
        .upd_en     (upd_en),
        .upd_ack    (upd_ack),
        .shift_reg  (shift_reg),
        .shift_cnt  (shift_cnt),
        .upd_data   (upd_data),
        .upd_valid  (upd_valid),
        .len_err    (len_err),
        .overrun    (overrun)
    );

`ifdef SCR1_TRGT_SIMULATION
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({rst_n_sync, fsm_dr_select,
                                 fsm_dr_capture, fsm_dr_shift,
                                 fsm_dr_update, din_serial,
                                 din_parallel, upd_ack}))
            else $error("scr1_tapc_dr_chain: X on inputs");
        end
    end
`endif

endmodule

// File: tb/tb_scr1_tapc_dr_chain.sv
// Bench for scr1_tapc_dr_chain: LSB-first W=8 table, MSB-first W=8
// and W=1 directed sequences, sync and async reset checks.
module tb_scr1_tapc_dr_chain;

    typedef struct packed {
        logic       rsync;
        logic       sel;
        logic       cap;
        logic       sh;
        logic       upd;
        logic       ack;
        logic       tdi;
        logic [7:0] dinp;
    } in_t;

    typedef struct {
        logic [6:0] ctl;
        logic [7:0] dinp;
        logic       e_dout;
        logic [7:0] e_par;
        logic [3:0] e_cnt;
        logic [2:0] e_flg;
        logic [7:0] e_upd;
    } vec_t;

    // ctl = {rsync, sel, cap, sh, upd, ack, tdi}
    localparam logic [6:0] IDLE   = 7'b1000000;
    localparam logic [6:0] CAP    = 7'b1110000;
    localparam logic [6:0] SH0    = 7'b1101000;
    localparam logic [6:0] SH1    = 7'b1101001;
    localparam logic [6:0] UPD    = 7'b1100100;
    localparam logic [6:0] ACK    = 7'b1100010;
    localparam logic [6:0] NSUPD  = 7'b1000100;
    localparam logic [6:0] NSCAP  = 7'b1010000;
    localparam logic [6:0] NSACK  = 7'b1000010;
    localparam logic [6:0] CAPUPD = 7'b1110100;
    localparam logic [6:0] UPDACK = 7'b1100110;
    localparam logic [6:0] SHUPD1 = 7'b1101101;
    localparam logic [6:0] RSSH1  = 7'b0101001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  in_l, in_m, in_1;

    logic       l_dout, l_vld, l_len, l_ovr;
    logic [7:0] l_par, l_upd;
    logic [3:0] l_cnt;
    logic       m_dout, m_vld, m_len, m_ovr;
    logic [7:0] m_par, m_upd;
    logic [3:0] m_cnt;
    logic       o_dout, o_vld, o_len, o_ovr;
    logic [0:0] o_par, o_upd;
    logic [1:0] o_cnt;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    scr1_tapc_dr_chain #(.SCR1_WIDTH(8)) dut_l (
        .clk(clk), .rst_n(rst_n), .rst_n_sync(in_l.rsync),
        .fsm_dr_select(in_l.sel), .fsm_dr_capture(in_l.cap),
        .fsm_dr_shift(in_l.sh), .fsm_dr_update(in_l.upd),
        .din_serial(in_l.tdi), .din_parallel(in_l.dinp),
        .dout_serial(l_dout), .dout_parallel(l_par),
        .upd_data(l_upd), .upd_valid(l_vld), .upd_ack(in_l.ack),
        .shift_cnt(l_cnt), .len_err(l_len), .overrun(l_ovr)
    );

    scr1_tapc_dr_chain #(
        .SCR1_WIDTH(8), .SCR1_RESET_VALUE(8'h5A), .SCR1_MSB_FIRST(1'b1)
    ) dut_m (
        .clk(clk), .rst_n(rst_n), .rst_n_sync(in_m.rsync),
        .fsm_dr_select(in_m.sel), .fsm_dr_capture(in_m.cap),
        .fsm_dr_shift(in_m.sh), .fsm_dr_update(in_m.upd),
        .din_serial(in_m.tdi), .din_parallel(in_m.dinp),
        .dout_serial(m_dout), .dout_parallel(m_par),
        .upd_data(m_upd), .upd_valid(m_vld), .upd_ack(in_m.ack),
        .shift_cnt(m_cnt), .len_err(m_len), .overrun(m_ovr)
    );

    scr1_tapc_dr_chain #(.SCR1_WIDTH(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .rst_n_sync(in_1.rsync),
        .fsm_dr_select(in_1.sel), .fsm_dr_capture(in_1.cap),
        .fsm_dr_shift(in_1.sh), .fsm_dr_update(in_1.upd),
        .din_serial(in_1.tdi), .din_parallel(in_1.dinp[0:0]),
        .dout_serial(o_dout), .dout_parallel(o_par),
        .upd_data(o_upd), .upd_valid(o_vld), .upd_ack(in_1.ack),
        .shift_cnt(o_cnt), .len_err(o_len), .overrun(o_ovr)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [6:0] c, input logic [7:0] d);
        in_t v;
        {v.rsync, v.sel, v.cap, v.sh, v.upd, v.ack, v.tdi} = c;
        v.dinp = d;
        return v;
    endfunction

    task automatic step(input int which, input logic [6:0] c,
                        input logic [7:0] d);
        case (which)
            0: in_l = mk(c, d);
            1: in_m = mk(c, d);
            default: in_1 = mk(c, d);
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] c, input logic [7:0] d,
                       input logic e_dout, input logic [7:0] e_par,
                       input logic [3:0] e_cnt, input logic [2:0] e_flg,
                       input logic [7:0] e_upd);
        vecs.push_back('{c, d, e_dout, e_par, e_cnt, e_flg, e_upd});
    endtask

    initial begin
        logic [7:0] cw;
        logic [7:0] tw;
        in_l = mk(IDLE, 8'h00);
        in_m = mk(IDLE, 8'h00);
        in_1 = mk(IDLE, 8'h00);

        // e_flg = {upd_valid, len_err, overrun}
        add(CAP,    8'hA5, 1'b1, 8'hA5, 4'd0, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b0, 8'hD2, 4'd1, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b1, 8'hE9, 4'd2, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b0, 8'hF4, 4'd3, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b0, 8'hFA, 4'd4, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b1, 8'hFD, 4'd5, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b0, 8'hFE, 4'd6, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b1, 8'hFF, 4'd7, 3'b000, 8'h00);
        add(SH1,    8'h00, 1'b1, 8'hFF, 4'd8, 3'b000, 8'h00);
        add(UPD,    8'h00, 1'b1, 8'hFF, 4'd8, 3'b100, 8'hFF);
        add(ACK,    8'h00, 1'b1, 8'hFF, 4'd8, 3'b000, 8'hFF);
        add(CAP,    8'hA5, 1'b1, 8'hA5, 4'd0, 3'b000, 8'hFF);
        add(SH0,    8'h00, 1'b0, 8'h52, 4'd1, 3'b000, 8'hFF);
        add(SH0,    8'h00, 1'b1, 8'h29, 4'd2, 3'b000, 8'hFF);
        add(SH0,    8'h00, 1'b0, 8'h14, 4'd3, 3'b000, 8'hFF);
        add(SH0,    8'h00, 1'b0, 8'h0A, 4'd4, 3'b000, 8'hFF);
        add(SH0,    8'h00, 1'b1, 8'h05, 4'd5, 3'b000, 8'hFF);
        add(UPD,    8'h00, 1'b1, 8'h05, 4'd5, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h02, 4'd6, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b1, 8'h01, 4'd7, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h00, 4'd8, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h00, 4'd9, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h00, 4'd9, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h00, 4'd9, 3'b110, 8'h05);
        add(SH0,    8'h00, 1'b0, 8'h00, 4'd9, 3'b110, 8'h05);
        add(UPD,    8'h00, 1'b0, 8'h00, 4'd9, 3'b111, 8'h00);
        add(ACK,    8'h00, 1'b0, 8'h00, 4'd9, 3'b011, 8'h00);
        add(NSUPD,  8'h00, 1'b0, 8'h00, 4'd9, 3'b011, 8'h00);
        add(NSCAP,  8'h33, 1'b0, 8'h00, 4'd9, 3'b011, 8'h00);
        add(CAPUPD, 8'hC3, 1'b1, 8'hC3, 4'd0, 3'b011, 8'h00);
        add(UPDACK, 8'h00, 1'b1, 8'hC3, 4'd0, 3'b111, 8'hC3);
        add(SHUPD1, 8'h00, 1'b1, 8'hE1, 4'd1, 3'b111, 8'hC3);
        add(SH0,    8'h00, 1'b0, 8'h70, 4'd2, 3'b111, 8'hC3);
        add(RSSH1,  8'h00, 1'b0, 8'h00, 4'd0, 3'b000, 8'h00);
        add(CAP,    8'h0F, 1'b1, 8'h0F, 4'd0, 3'b000, 8'h00);

        // Asynchronous reset held: outputs must already be at reset values
        #12;
        chk("rst l par", l_par, 8'h00);
        chk("rst l cnt", l_cnt, 4'd0);
        chk("rst l flags", {l_vld, l_len, l_ovr}, 3'b000);
        chk("rst m par", m_par, 8'h5A);
        chk("rst m upd", m_upd, 8'h5A);
        chk("rst m dout", m_dout, 1'b0);
        chk("rst 1 par", o_par, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(0, vecs[i].ctl, vecs[i].dinp);
            chk($sformatf("v%0d dout", i), l_dout, vecs[i].e_dout);
            chk($sformatf("v%0d par", i), l_par, vecs[i].e_par);
            chk($sformatf("v%0d cnt", i), l_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d flags", i), {l_vld, l_len, l_ovr},
                vecs[i].e_flg);
            chk($sformatf("v%0d upd", i), l_upd, vecs[i].e_upd);
        end
        step(0, IDLE, 8'h00);

        // MSB first: TDO walks A5 from bit 7, TDI word 3C lands intact
        cw = 8'hA5;
        tw = 8'h3C;
        step(1, CAP, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m tdo%0d", i), m_dout, cw[7-i]);
            step(1, tw[7-i] ? SH1 : SH0, 8'h00);
        end
        chk("m par", m_par, 8'h3C);
        chk("m cnt", m_cnt, 4'd8);
        step(1, UPD, 8'h00);
        chk("m upd", m_upd, 8'h3C);
        chk("m flags", {m_vld, m_len, m_ovr}, 3'b100);
        step(1, CAP, 8'h96);
        step(1, UPDACK, 8'h00);
        chk("m updack data", m_upd, 8'h96);
        chk("m updack flags", {m_vld, m_len, m_ovr}, 3'b110);
        step(1, NSACK, 8'h00);
        chk("m ack nosel", m_vld, 1'b0);
        step(1, ACK, 8'h00);
        chk("m ack idle", {m_vld, m_ovr}, 2'b00);
        step(1, UPD, 8'h00);
        chk("m upd2 vld", m_vld, 1'b1);
        in_m = mk(IDLE, 8'h00);

        // Width 1
        step(2, CAP, 8'h01);
        chk("w1 cap1", {o_dout, o_par, o_cnt}, 4'b1100);
        step(2, CAP, 8'h00);
        chk("w1 cap0", o_dout, 1'b0);
        step(2, SH1, 8'h00);
        chk("w1 sh1", {o_dout, o_cnt}, 3'b101);
        step(2, SH0, 8'h00);
        chk("w1 sh0", {o_dout, o_cnt}, 3'b010);
        step(2, SH0, 8'h00);
        chk("w1 sat", o_cnt, 2'd2);
        step(2, UPD, 8'h00);
        chk("w1 upd", {o_upd, o_vld, o_len, o_ovr}, 4'b0110);
        step(2, CAP, 8'h00);
        step(2, SH1, 8'h00);
        step(2, UPD, 8'h00);
        chk("w1 upd2", {o_upd, o_vld, o_len, o_ovr}, 4'b1101);
        in_1 = mk(IDLE, 8'h00);

        // Asynchronous reset between edges clears pending update
        #2;
        rst_n = 1'b0;
        #1;
        chk("async m vld", m_vld, 1'b0);
        chk("async m par", m_par, 8'h5A);
        chk("async m upd", m_upd, 8'h5A);
        chk("async 1 ovr", o_ovr, 1'b0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
